// File: rtl/cim_gemm_macro_param.sv
// Compute-in-memory GeMM macro: ROWS x COLS signed weight array, bit-serial
// activations (MSB first) and per-channel output registers with optional accumulation.
module cim_gemm_macro_param #(
    parameter int ROWS  = 16,
    parameter int COLS  = 4,
    parameter int WBITS = 4,
    parameter int ABITS = 4,
    parameter int ACC_W = 20
) (
    input  logic                       CLK,
    input  logic                       RES,
    input  logic                       cs,
    input  logic                       web,
    input  logic [$clog2(ROWS)-1:0]    address,
    input  logic [COLS*WBITS-1:0]      weight_data,
    input  logic                       cimeb,
    input  logic [ROWS*ABITS-1:0]      input_data,
    input  logic                       signed_act,
    input  logic                       partial_sum_eb,
    input  logic                       reset_output_reg,
    input  logic [$clog2(COLS)-1:0]    output_reg,
    output logic                       busy,
    output logic                       done,
    output logic [ACC_W-1:0]           cim_output,
    output logic [1:0]                 dbg_state
);

    localparam int AW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int KW     = (ABITS > 1) ? $clog2(ABITS) : 1;
    localparam int P_W    = WBITS + $clog2(ROWS);
    localparam int PROD_W = WBITS + ABITS + $clog2(ROWS);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_COMPUTE   = 2'd1,
        S_WRITEBACK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [COLS*WBITS-1:0]     w_mem   [ROWS];
    logic [COLS*WBITS-1:0]     row_eff [ROWS];
    logic [ABITS-1:0]          act_q   [ROWS];
    logic signed [P_W-1:0]     p_sum   [COLS];
    logic signed [PROD_W-1:0]  prod    [COLS];
    logic [ACC_W-1:0]          prod_ext[COLS];
    logic [ACC_W-1:0]          out_reg [COLS];

    logic [KW-1:0]             k_q;
    logic                      signed_q;
    logic                      acc_q;
    logic                      sub_q;
    logic [AW-1:0]             sub_addr_q;
    logic [COLS*WBITS-1:0]     sub_row_q;
    logic                      done_q;

    logic idle;
    logic addr_ok;
    logic wr_en;
    logic start;
    logic clr;

    // Handshake: start is accepted only in IDLE (busy low); busy stays high from the
    // edge after start until the writeback edge, and done pulses for the cycle after it.
    assign idle    = (state_q == S_IDLE);
    assign addr_ok = ({1'b0, address} < (AW+1)'(ROWS));
    assign wr_en   = cs & ~web & idle & addr_ok;
    assign start   = cs & ~cimeb & idle;
    assign clr     = cs & reset_output_reg;

    assign done      = done_q;
    assign dbg_state = state_q;

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (k_q == '0) state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Weight array is deliberately left out of reset so it survives RES.
    always_ff @(posedge CLK) begin
        if (wr_en) w_mem[address] <= weight_data;
    end

    // A write landing on the start edge must not leak into this run: the old row is
    // kept aside and substituted for its address while computing.
    always_comb begin
        for (int r = 0; r < ROWS; r++) begin
            row_eff[r] = w_mem[r];
            if (sub_q && (sub_addr_q == AW'(r))) row_eff[r] = sub_row_q;
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            p_sum[c] = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (act_q[r][k_q])
                    p_sum[c] = p_sum[c] + P_W'($signed(row_eff[r][c*WBITS +: WBITS]));
            end
        end
    end

    always_comb begin
        for (int c = 0; c < COLS; c++) prod_ext[c] = ACC_W'(prod[c]);
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            k_q        <= '0;
            signed_q   <= 1'b0;
            acc_q      <= 1'b0;
            sub_q      <= 1'b0;
            sub_addr_q <= '0;
            sub_row_q  <= '0;
            done_q     <= 1'b0;
            for (int r = 0; r < ROWS; r++) act_q[r] <= '0;
            for (int c = 0; c < COLS; c++) begin
                prod[c]    <= '0;
                out_reg[c] <= '0;
            end
        end else begin
            done_q <= (state_q == S_WRITEBACK);

            if (start) begin
                k_q        <= KW'(ABITS - 1);
                signed_q   <= signed_act;
                acc_q      <= ~partial_sum_eb;
                sub_q      <= wr_en;
                sub_addr_q <= address;
                sub_row_q  <= w_mem[address];
                for (int r = 0; r < ROWS; r++) act_q[r] <= input_data[r*ABITS +: ABITS];
                for (int c = 0; c < COLS; c++) prod[c] <= '0;
            end

            if (state_q == S_COMPUTE) begin
                k_q <= k_q - 1'b1;
                for (int c = 0; c < COLS; c++) begin
                    // The MSB of a two's-complement activation carries negative weight.
                    if (k_q == KW'(ABITS - 1))
                        prod[c] <= signed_q ? -PROD_W'(p_sum[c]) : PROD_W'(p_sum[c]);
                    else
                        prod[c] <= (prod[c] <<< 1) + PROD_W'(p_sum[c]);
                end
            end

            // A clear during writeback wins over accumulation, leaving a plain overwrite.
            if (state_q == S_WRITEBACK) begin
                for (int c = 0; c < COLS; c++)
                    out_reg[c] <= (acc_q && !clr) ? out_reg[c] + prod_ext[c] : prod_ext[c];
            end else if (clr) begin
                for (int c = 0; c < COLS; c++) out_reg[c] <= '0;
            end
        end
    end

    always_comb begin
        cim_output = '0;
        if ({1'b0, output_reg} < (CW+1)'(COLS)) cim_output = out_reg[output_reg];
    end

endmodule

// File: tb/tb_cim_gemm_macro_param.sv
// Directed bench for cim_gemm_macro_param: hand-computed dot products, latency,
// accumulate/clear modes, ignored inputs while busy, mid-run reset and chip select.
module tb_cim_gemm_macro_param;

    localparam int ROWS  = 16;
    localparam int COLS  = 4;
    localparam int WBITS = 4;
    localparam int ABITS = 4;
    localparam int ACC_W = 20;

    // ch3=7, ch2=0, ch1=-1, ch0=1
    localparam logic [15:0] ROW_W = 16'h70F1;

    logic                    CLK = 1'b0;
    logic                    RES;
    logic                    cs;
    logic                    web;
    logic [3:0]              address;
    logic [COLS*WBITS-1:0]   weight_data;
    logic                    cimeb;
    logic [ROWS*ABITS-1:0]   input_data;
    logic                    signed_act;
    logic                    partial_sum_eb;
    logic                    reset_output_reg;
    logic [1:0]              output_reg;
    logic                    busy;
    logic                    done;
    logic [ACC_W-1:0]        cim_output;
    logic [1:0]              dbg_state;

    int n_total = 0;
    int n_pass  = 0;

    cim_gemm_macro_param #(
        .ROWS(ROWS), .COLS(COLS), .WBITS(WBITS), .ABITS(ABITS), .ACC_W(ACC_W)
    ) dut (
        .CLK(CLK),
        .RES(RES),
        .cs(cs),
        .web(web),
        .address(address),
        .weight_data(weight_data),
        .cimeb(cimeb),
        .input_data(input_data),
        .signed_act(signed_act),
        .partial_sum_eb(partial_sum_eb),
        .reset_output_reg(reset_output_reg),
        .output_reg(output_reg),
        .busy(busy),
        .done(done),
        .cim_output(cim_output),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic read_ch(input string tag, input logic [1:0] ch, input logic [31:0] exp);
        output_reg = ch;
        #1;
        check(tag, 32'(cim_output), exp);
    endtask

    task automatic write_row(input logic [3:0] addr, input logic [15:0] data);
        cs          = 1'b1;
        web         = 1'b0;
        address     = addr;
        weight_data = data;
        tick();
        web = 1'b1;
    endtask

    task automatic start(input logic [3:0] act, input logic sgn, input logic psum_eb);
        cs             = 1'b1;
        input_data     = {ROWS{act}};
        signed_act     = sgn;
        partial_sum_eb = psum_eb;
        cimeb          = 1'b0;
        tick();
        cimeb = 1'b1;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        bit saw_done;
        RES              = 1'b1;
        cs               = 1'b0;
        web              = 1'b1;
        address          = '0;
        weight_data      = '0;
        cimeb            = 1'b1;
        input_data       = '0;
        signed_act       = 1'b0;
        partial_sum_eb   = 1'b1;
        reset_output_reg = 1'b0;
        output_reg       = '0;
        tick();
        tick();
        RES = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        for (int c = 0; c < COLS; c++) read_ch($sformatf("rst_out%0d", c), 2'(c), 32'd0);

        for (int r = 0; r < ROWS; r++) write_row(4'(r), ROW_W);

        // Test 1: exact latency, all-ones activations, unsigned overwrite
        start(4'hF, 1'b0, 1'b1);
        check("t1_busy_e0", 32'(busy), 32'd1);
        check("t1_done_e0", 32'(done), 32'd0);
        for (int e = 1; e <= 4; e++) begin
            tick();
            check($sformatf("t1_busy_e%0d", e), 32'(busy), 32'd1);
            check($sformatf("t1_done_e%0d", e), 32'(done), 32'd0);
        end
        tick();
        check("t1_busy_e5", 32'(busy), 32'd0);
        check("t1_done_e5", 32'(done), 32'd1);
        read_ch("t1_out0", 2'd0, 32'd240);
        read_ch("t1_out1", 2'd1, 32'hFFF10);
        read_ch("t1_out3", 2'd3, 32'd1680);
        tick();
        check("t1_done_e6", 32'(done), 32'd0);

        // Test 2: activation 1000b, signed (-8) vs unsigned (8) against w=-1
        start(4'h8, 1'b1, 1'b1);
        wait_done("t2s_done");
        read_ch("t2s_out1", 2'd1, 32'h00080);
        start(4'h8, 1'b0, 1'b1);
        wait_done("t2u_done");
        read_ch("t2u_out1", 2'd1, 32'hFFF80);

        // Test 3: accumulate, clear during writeback, clear in idle
        start(4'hF, 1'b0, 1'b1);
        wait_done("t3a_done");
        read_ch("t3a_out0", 2'd0, 32'd240);
        start(4'hF, 1'b0, 1'b0);
        wait_done("t3b_done");
        read_ch("t3b_out0", 2'd0, 32'd480);
        start(4'hF, 1'b0, 1'b0);
        repeat (4) tick();
        check("t3c_state_wb", 32'(dbg_state), 32'd2);
        reset_output_reg = 1'b1;
        tick();
        reset_output_reg = 1'b0;
        check("t3c_done", 32'(done), 32'd1);
        read_ch("t3c_out0", 2'd0, 32'd240);
        read_ch("t3c_out1", 2'd1, 32'hFFF10);
        reset_output_reg = 1'b1;
        tick();
        reset_output_reg = 1'b0;
        read_ch("t3d_out0", 2'd0, 32'd0);
        read_ch("t3d_out3", 2'd3, 32'd0);

        // Test 4: start pulse and row-0 write during compute are ignored
        start(4'hF, 1'b0, 1'b1);
        tick();
        cimeb       = 1'b0;
        web         = 1'b0;
        address     = 4'd0;
        weight_data = 16'h0000;
        tick();
        cimeb       = 1'b1;
        web         = 1'b1;
        weight_data = ROW_W;
        wait_done("t4a_done");
        read_ch("t4a_out0", 2'd0, 32'd240);
        tick();
        check("t4_no_queue", 32'(busy), 32'd0);
        start(4'hF, 1'b0, 1'b1);
        wait_done("t4b_done");
        read_ch("t4b_out0", 2'd0, 32'd240);

        // Test 5: reset in the second compute cycle
        start(4'hF, 1'b0, 1'b1);
        tick();
        RES = 1'b1;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_out0", 32'(cim_output), 32'd0);
        RES = 1'b0;
        saw_done = 1'b0;
        repeat (6) begin
            tick();
            if (done) saw_done = 1'b1;
        end
        check("t5_no_done", 32'(saw_done), 32'd0);
        start(4'hF, 1'b0, 1'b1);
        wait_done("t5b_done");
        read_ch("t5b_out0", 2'd0, 32'd240);

        // Test 6: deselected chip ignores write and start; channel 3 readout
        tick();
        cs          = 1'b0;
        web         = 1'b0;
        cimeb       = 1'b0;
        address     = 4'd0;
        weight_data = 16'h0000;
        tick();
        check("t6_no_start", 32'(busy), 32'd0);
        tick();
        check("t6_no_start2", 32'(busy), 32'd0);
        web         = 1'b1;
        cimeb       = 1'b1;
        weight_data = ROW_W;
        start(4'hF, 1'b0, 1'b1);
        wait_done("t6_done");
        read_ch("t6_out0", 2'd0, 32'd240);
        read_ch("t6_out3", 2'd3, 32'd1680);
        read_ch("t6_out2", 2'd2, 32'd0);

        // Write and start on the same edge: this run sees the old row 0
        tick();
        web         = 1'b0;
        address     = 4'd0;
        weight_data = 16'h70F0;
        start(4'hF, 1'b0, 1'b1);
        web         = 1'b1;
        weight_data = ROW_W;
        wait_done("t7a_done");
        read_ch("t7a_out0", 2'd0, 32'd240);
        start(4'hF, 1'b0, 1'b1);
        wait_done("t7b_done");
        read_ch("t7b_out0", 2'd0, 32'd225);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
